// File: rtl/mux_8_1_rr_arbiter_v.sv
`default_nettype none
// ============================================================================
// Module   : mux_8_1_rr_arbiter_v
// Purpose  : Round-robin arbiter sharing one 8:1 single-bit mux among eight
//            requesters. Issues a registered one-hot grant and drives the mux
//            select code and enable. Each tenure lasts at most MAX_HOLD cycles
//            and is followed by exactly one dead (GAP) cycle.
// Ports    : i_clk      - clock, rising edge
//            i_rst      - asynchronous active-high reset
//            i_en       - arbiter enable (0 releases grant, blocks new ones)
//            i_req[7:0] - request vector, bit k = requester k
//            i_done     - current grantee finished, release at next edge
//            o_gnt[7:0] - one-hot grant (registered)
//            o_gnt_vld  - grant valid (|o_gnt)
//            o_sel_code - mux select, index of current/last grantee
//            o_mux_en   - mux enable (== o_gnt_vld)
//            o_hold_cnt - cycles elapsed in current grant
// Revision : 1.0 - initial release
// ============================================================================
module mux_8_1_rr_arbiter_v #(
  parameter int MAX_HOLD = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [7:0] i_req,
  input  logic       i_done,
  output logic [7:0] o_gnt,
  output logic       o_gnt_vld,
  output logic [2:0] o_sel_code,
  output logic       o_mux_en,
  output logic [3:0] o_hold_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [3:0] c_HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_ptr, w_ptr_nxt;
  logic [7:0] r_gnt, w_gnt_nxt;
  logic [2:0] r_sel, w_sel_nxt;
  logic [3:0] r_hold, w_hold_nxt;

  logic       w_found;
  logic [2:0] w_win;
  logic [2:0] w_idx;
  logic       w_release;
  logic       w_start;

  // Rotating priority search: ptr has highest priority, ptr-1 the lowest.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = r_ptr;
    for (int i = 0; i < 8; i++) begin
      w_idx = r_ptr + 3'(i);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_start   = i_en & w_found;
  // Any combination of release causes collapses into a single release.
  assign w_release = i_done | ~i_req[r_sel] | ~i_en | (r_hold == c_HOLD_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_hold_nxt  = r_hold;
    unique case (r_state)
      IDLE, GAP: begin
        if (w_start) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = 8'b1 << w_win;
          w_sel_nxt   = w_win;
          w_hold_nxt  = 4'd0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_state_nxt = GAP;
          w_gnt_nxt   = 8'd0;
          w_hold_nxt  = 4'd0;
          w_ptr_nxt   = r_sel + 3'd1;   // released winner drops to lowest priority
        end else begin
          w_hold_nxt  = r_hold + 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_ptr   <= 3'd0;
      r_gnt   <= 8'd0;
      r_sel   <= 3'd0;
      r_hold  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  assign o_gnt      = r_gnt;
  assign o_gnt_vld  = |r_gnt;
  assign o_mux_en   = |r_gnt;
  assign o_sel_code = r_sel;
  assign o_hold_cnt = r_hold;

endmodule
`default_nettype wire
